// File: rtl/i2si_pkg.sv
// Shared definitions for the i2si write-side blocks.
// Holds the default data/counter widths, the channel encodings and the
// output-stage state type used by the FIFO write arbiter.
package i2si_pkg;

  localparam int   I2SI_DATA_W = 8;
  localparam int   I2SI_CNT_W  = 4;
  localparam logic I2SI_CH_L   = 1'b0;
  localparam logic I2SI_CH_R   = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } out_st_e;

endpackage

// File: rtl/i2si_fifo_wr_arb_if.sv
// Handshake bundle between the two deserializer producers, the write
// arbiter and the FIFO input port.
//   req0_*        : left producer rts/rtr + byte
//   req1_*        : right producer rts/rtr + byte
//   fifo_inp_*    : byte toward the FIFO, rts/rtr handshake
//   fifo_counter  : FIFO occupancy
//   grant_id      : source channel of the byte in the output stage
//   almost_full   : registered occupancy watermark flag
// slave  = arbiter side, master = producers/FIFO side.
interface i2si_fifo_wr_arb_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);

  logic              req0_rts;
  logic [DATA_W-1:0] req0_data;
  logic              req0_rtr;
  logic              req1_rts;
  logic [DATA_W-1:0] req1_data;
  logic              req1_rtr;
  logic              fifo_inp_rts;
  logic [DATA_W-1:0] fifo_inp_data;
  logic              fifo_inp_rtr;
  logic [CNT_W-1:0]  fifo_counter;
  logic              grant_id;
  logic              almost_full;

  modport slave (
    input  req0_rts, req0_data, req1_rts, req1_data, fifo_inp_rtr, fifo_counter,
    output req0_rtr, req1_rtr, fifo_inp_rts, fifo_inp_data, grant_id, almost_full
  );

  modport master (
    output req0_rts, req0_data, req1_rts, req1_data, fifo_inp_rtr, fifo_counter,
    input  req0_rtr, req1_rtr, fifo_inp_rts, fifo_inp_data, grant_id, almost_full
  );

endinterface

// File: rtl/i2si_hold_reg.sv
// 1-deep rts/rtr holding register for one producer channel.
//   clk, rst_n  : clock, async active-low reset
//   in_rts_i    : producer has a byte
//   in_data_i   : producer byte
//   in_rtr_o    : register empty, can accept
//   clr_i       : byte taken by the arbiter this cycle
//   valid_o     : register holds a byte
//   data_o      : held byte
module i2si_hold_reg
  import i2si_pkg::*;
#(
  parameter int DATA_W = I2SI_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_rts_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_rtr_o,
  input  logic              clr_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // rtr comes straight from the flop so producers see no comb path.
  // A clear and an accept can never coincide: clear needs valid, accept needs !valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (in_rts_i && !valid_q) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
    end
  end

  assign in_rtr_o = !valid_q;
  assign valid_o  = valid_q;
  assign data_o   = data_q;

endmodule

// File: rtl/i2si_fifo_wr_arb.sv
// Write-side arbiter sharing the i2si byte FIFO input between the left and
// right deserializers. Each side has a 1-deep hold; a grant (round-robin or
// strict L/R alternation) loads a registered output stage that drives the
// FIFO rts/rtr handshake. Also registers an almost-full watermark flag.
//   clk, rst_n : clock, async active-low reset
//   bus        : i2si_fifo_wr_arb_if.slave (producer, FIFO and status signals)
//
// state   | meaning
// --------+------------------------------------------------
// ST_IDLE | output stage empty, fifo_inp_rts low
// ST_PEND | byte presented to FIFO, held until fifo_inp_rtr
module i2si_fifo_wr_arb
  import i2si_pkg::*;
#(
  parameter int DATA_W      = I2SI_DATA_W,
  parameter int CNT_W       = I2SI_CNT_W,
  parameter int HI_WM       = 6,
  parameter int STEREO_LOCK = 1
) (
  input logic               clk,
  input logic               rst_n,
  i2si_fifo_wr_arb_if.slave bus
);

  logic [1:0]        hold_valid;
  logic [DATA_W-1:0] hold_data_l;
  logic [DATA_W-1:0] hold_data_r;
  logic [1:0]        clr_d;

  out_st_e           state_q;
  logic [DATA_W-1:0] out_data_q;
  logic              grant_id_q;
  logic              last_grant_q;
  logic              almost_full_q;

  logic              xfer_d;
  logic              load_ok_d;
  logic              have_d;
  logic              grant_d;
  logic              load_d;
  logic [DATA_W-1:0] load_data_d;

  i2si_hold_reg #(.DATA_W(DATA_W)) u_hold_l (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_rts_i  (bus.req0_rts),
    .in_data_i (bus.req0_data),
    .in_rtr_o  (bus.req0_rtr),
    .clr_i     (clr_d[I2SI_CH_L]),
    .valid_o   (hold_valid[I2SI_CH_L]),
    .data_o    (hold_data_l)
  );

  i2si_hold_reg #(.DATA_W(DATA_W)) u_hold_r (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_rts_i  (bus.req1_rts),
    .in_data_i (bus.req1_data),
    .in_rtr_o  (bus.req1_rtr),
    .clr_i     (clr_d[I2SI_CH_R]),
    .valid_o   (hold_valid[I2SI_CH_R]),
    .data_o    (hold_data_r)
  );

  always_comb begin
    xfer_d    = (state_q == ST_PEND) && bus.fifo_inp_rtr;
    // Reloading on the transfer cycle keeps the FIFO fed at 1 byte/cycle.
    load_ok_d = (state_q == ST_IDLE) || xfer_d;
    grant_d   = ~last_grant_q;
    have_d    = 1'b0;
    if (STEREO_LOCK != 0) begin
      // Strict alternation: the side that went last must wait its turn.
      have_d = hold_valid[grant_d];
    end else begin
      have_d = |hold_valid;
      // Single requester wins outright; with both valid the other side from last.
      if (hold_valid != 2'b11) grant_d = hold_valid[I2SI_CH_R];
    end
    load_d = load_ok_d && have_d;
    clr_d  = 2'b00;
    if (load_d) clr_d[grant_d] = 1'b1;
    load_data_d = grant_d ? hold_data_r : hold_data_l;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      out_data_q    <= '0;
      grant_id_q    <= I2SI_CH_L;
      last_grant_q  <= I2SI_CH_R;
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= (bus.fifo_counter >= CNT_W'(HI_WM));
      if (load_d) begin
        out_data_q   <= load_data_d;
        grant_id_q   <= grant_d;
        last_grant_q <= grant_d;
        state_q      <= ST_PEND;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_IDLE;
          ST_PEND: if (xfer_d) state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.fifo_inp_rts  = (state_q == ST_PEND);
  assign bus.fifo_inp_data = out_data_q;
  assign bus.grant_id      = grant_id_q;
  assign bus.almost_full   = almost_full_q;

endmodule

// File: tb/tb_i2si_fifo_wr_arb.sv
// Testbench for i2si_fifo_wr_arb: two instances (round-robin and stereo
// lock) driven by queue-based producers, with a scoreboard monitor per DUT.
module tb_i2si_fifo_wr_arb;
  import i2si_pkg::*;

  localparam int HI_WM = 6;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2si_fifo_wr_arb_if #(.DATA_W(8), .CNT_W(4)) bus [2] ();

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] src_l  [2][$];
  logic [7:0] src_r  [2][$];
  logic [7:0] mq_l   [2][$];
  logic [7:0] mq_r   [2][$];
  logic [7:0] seen_d [2][$];
  logic       seen_g [2][$];
  bit         gate_rand [2];
  int         rdy_mode  [2];
  bit         cnt_rand  [2];
  logic [3:0] cnt_val   [2];
  bit         stereo    [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar d = 0; d < 2; d++) begin : g_dut
    i2si_fifo_wr_arb #(.DATA_W(8), .CNT_W(4), .HI_WM(HI_WM), .STEREO_LOCK(d)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus[d])
    );

    bit         acc_l = 1'b0, acc_r = 1'b0, keep_l, keep_r;
    bit         exp_ch = 1'b0, have_prev = 1'b0, ch;
    logic [3:0] prev_cnt;
    logic [7:0] exp_b;

    // Producers and FIFO side: a presented byte stays up until it is accepted.
    always @(negedge clk) begin
      if (acc_l) void'(src_l[d].pop_front());
      if (acc_r) void'(src_r[d].pop_front());
      keep_l = bus[d].req0_rts && !acc_l;
      keep_r = bus[d].req1_rts && !acc_r;
      bus[d].req0_rts  = (src_l[d].size() != 0) && (keep_l || !gate_rand[d] || ($urandom_range(0, 2) != 0));
      bus[d].req0_data = (src_l[d].size() != 0) ? src_l[d][0] : 8'h00;
      bus[d].req1_rts  = (src_r[d].size() != 0) && (keep_r || !gate_rand[d] || ($urandom_range(0, 2) != 0));
      bus[d].req1_data = (src_r[d].size() != 0) ? src_r[d][0] : 8'h00;
      case (rdy_mode[d])
        0:       bus[d].fifo_inp_rtr = 1'b1;
        1:       bus[d].fifo_inp_rtr = ($urandom_range(0, 3) != 0);
        default: bus[d].fifo_inp_rtr = 1'b0;
      endcase
      bus[d].fifo_counter = cnt_rand[d] ? 4'($urandom_range(0, 15)) : cnt_val[d];
      acc_l = rst_n && bus[d].req0_rts && bus[d].req0_rtr;
      acc_r = rst_n && bus[d].req1_rts && bus[d].req1_rtr;
    end

    // Scoreboard: accepted bytes queue per channel; each FIFO transfer must
    // be the oldest outstanding byte of the channel it claims.
    always @(negedge clk) begin
      #1;
      if (!rst_n) begin
        mq_l[d].delete();
        mq_r[d].delete();
        exp_ch    = 1'b0;
        have_prev = 1'b0;
        check("rst_fifo_rts", 32'(bus[d].fifo_inp_rts), 32'd0);
        check("rst_almost_full", 32'(bus[d].almost_full), 32'd0);
      end else begin
        if (bus[d].fifo_inp_rts && bus[d].fifo_inp_rtr) begin
          ch = bus[d].grant_id;
          if (stereo[d]) begin
            check("stereo_order", 32'(ch), 32'(exp_ch));
            exp_ch = ~exp_ch;
          end
          check("byte_outstanding", 32'(ch ? mq_r[d].size() : mq_l[d].size()) != 0 ? 32'd1 : 32'd0, 32'd1);
          if (!ch && mq_l[d].size() != 0) begin
            exp_b = mq_l[d].pop_front();
            check("fifo_data_l", 32'(bus[d].fifo_inp_data), 32'(exp_b));
          end else if (ch && mq_r[d].size() != 0) begin
            exp_b = mq_r[d].pop_front();
            check("fifo_data_r", 32'(bus[d].fifo_inp_data), 32'(exp_b));
          end
          seen_d[d].push_back(bus[d].fifo_inp_data);
          seen_g[d].push_back(ch);
        end
        if (bus[d].req0_rts && bus[d].req0_rtr) mq_l[d].push_back(bus[d].req0_data);
        if (bus[d].req1_rts && bus[d].req1_rtr) mq_r[d].push_back(bus[d].req1_data);
        if (have_prev) check("almost_full", 32'(bus[d].almost_full), (prev_cnt >= 4'(HI_WM)) ? 32'd1 : 32'd0);
        prev_cnt  = bus[d].fifo_counter;
        have_prev = 1'b1;
      end
    end
  end

  task automatic wait_drain(input int d, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #2;
      ok = (src_l[d].size() == 0) && (src_r[d].size() == 0) &&
           (mq_l[d].size() == 0) && (mq_r[d].size() == 0);
    end
    check("drain_in_budget", 32'(ok), 32'd1);
  endtask

  task automatic check_seen(input int d, input string name, input logic [7:0] b, input logic g, input int idx);
    if (seen_d[d].size() > idx) begin
      check({name, "_data"}, 32'(seen_d[d][idx]), 32'(b));
      check({name, "_gid"}, 32'(seen_g[d][idx]), 32'(g));
    end else begin
      check({name, "_present"}, 32'(seen_d[d].size()), 32'(idx + 1));
    end
  endtask

  logic [7:0] alt_b [8];
  logic [3:0] af_v  [4];
  logic       af_e  [4];

  initial begin
    #4_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic af_prev;
    bit   ok;
    alt_b = '{8'h11, 8'hA1, 8'h12, 8'hA2, 8'h13, 8'hA3, 8'h14, 8'hA4};
    af_v  = '{4'd5, 4'd6, 4'd7, 4'd5};
    af_e  = '{1'b0, 1'b1, 1'b1, 1'b0};
    stereo[0] = 1'b0;
    stereo[1] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      gate_rand[d] = 1'b0;
      rdy_mode[d]  = 0;
      cnt_rand[d]  = 1'b0;
      cnt_val[d]   = 4'd0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Reset state, idle, FIFO ready
    @(negedge clk);
    #1;
    check("idle_req0_rtr_a", 32'(bus[0].req0_rtr), 32'd1);
    check("idle_req1_rtr_a", 32'(bus[0].req1_rtr), 32'd1);
    check("idle_rts_a", 32'(bus[0].fifo_inp_rts), 32'd0);
    check("idle_gid_a", 32'(bus[0].grant_id), 32'd0);
    check("idle_af_a", 32'(bus[0].almost_full), 32'd0);
    check("idle_req0_rtr_b", 32'(bus[1].req0_rtr), 32'd1);
    check("idle_req1_rtr_b", 32'(bus[1].req1_rtr), 32'd1);
    check("idle_rts_b", 32'(bus[1].fifo_inp_rts), 32'd0);
    check("idle_gid_b", 32'(bus[1].grant_id), 32'd0);
    #1;

    // Round-robin, both producers every cycle
    for (int i = 0; i < 4; i++) begin
      src_l[0].push_back(8'h11 + 8'(i));
      src_r[0].push_back(8'hA1 + 8'(i));
    end
    wait_drain(0, 100);
    check("rr_count", 32'(seen_d[0].size()), 32'd8);
    for (int i = 0; i < 8; i++) check_seen(0, "rr", alt_b[i], 1'(i % 2), i);

    // Stereo lock: left 0x21,0x22 alone, then right 0xB1
    src_l[1].push_back(8'h21);
    src_l[1].push_back(8'h22);
    repeat (8) @(negedge clk);
    #1;
    check("sl_count_1", 32'(seen_d[1].size()), 32'd1);
    check_seen(1, "sl_first", 8'h21, 1'b0, 0);
    check("sl_req0_rtr_held", 32'(bus[1].req0_rtr), 32'd0);
    check("sl_req1_rtr", 32'(bus[1].req1_rtr), 32'd1);
    check("sl_rts_idle", 32'(bus[1].fifo_inp_rts), 32'd0);
    #1;
    src_r[1].push_back(8'hB1);
    wait_drain(1, 100);
    check("sl_count_3", 32'(seen_d[1].size()), 32'd3);
    check_seen(1, "sl_second", 8'hB1, 1'b1, 1);
    check_seen(1, "sl_third", 8'h22, 1'b0, 2);

    // almost_full watermark, one cycle late
    af_prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cnt_val[0] = af_v[i];
      @(negedge clk);
      #1;
      check("af_not_yet", 32'(bus[0].almost_full), 32'(af_prev));
      @(negedge clk);
      #1;
      check("af_value", 32'(bus[0].almost_full), 32'(af_e[i]));
      af_prev = af_e[i];
      #1;
    end

    // FIFO full for 10 cycles
    seen_d[0].delete();
    seen_g[0].delete();
    rdy_mode[0] = 2;
    for (int i = 0; i < 4; i++) src_l[0].push_back(8'h31 + 8'(i));
    src_r[0].push_back(8'hC1);
    src_r[0].push_back(8'hC2);
    repeat (4) @(negedge clk);
    #1;
    check("full_req0_rtr", 32'(bus[0].req0_rtr), 32'd0);
    check("full_req1_rtr", 32'(bus[0].req1_rtr), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("full_rts", 32'(bus[0].fifo_inp_rts), 32'd1);
      check("full_data_frozen", 32'(bus[0].fifo_inp_data), 32'h31);
      check("full_rtr_both", 32'({bus[0].req0_rtr, bus[0].req1_rtr}), 32'd0);
    end
    #1;
    rdy_mode[0] = 0;
    wait_drain(0, 100);
    check("full_count", 32'(seen_d[0].size()), 32'd6);
    check_seen(0, "full_b0", 8'h31, 1'b0, 0);
    check_seen(0, "full_b1", 8'hC1, 1'b1, 1);
    check_seen(0, "full_b2", 8'h32, 1'b0, 2);

    // Randomized traffic on both instances
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 120; i++) begin
        src_l[d].push_back(8'($urandom));
        src_r[d].push_back(8'($urandom));
      end
      gate_rand[d] = 1'b1;
      rdy_mode[d]  = 1;
      cnt_rand[d]  = 1'b1;
    end
    wait_drain(0, 3000);
    wait_drain(1, 3000);
    for (int d = 0; d < 2; d++) begin
      gate_rand[d] = 1'b0;
      rdy_mode[d]  = 0;
      cnt_rand[d]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    #2;

    // Reset while 0x5A is pending
    seen_d[0].delete();
    seen_g[0].delete();
    rdy_mode[0] = 2;
    src_l[0].push_back(8'h5A);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = bus[0].fifo_inp_rts && (bus[0].fifo_inp_data == 8'h5A);
    end
    check("pend_5a_reached", 32'(ok), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rts_drop", 32'(bus[0].fifo_inp_rts), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #2;
    rdy_mode[0] = 0;
    src_l[0].push_back(8'h61);
    src_r[0].push_back(8'hC1);
    wait_drain(0, 100);
    check("post_rst_count", 32'(seen_d[0].size()), 32'd2);
    check_seen(0, "post_rst_first", 8'h61, 1'b0, 0);
    check_seen(0, "post_rst_second", 8'hC1, 1'b1, 1);

    for (int d = 0; d < 2; d++) begin
      check("end_model_empty", 32'(mq_l[d].size() + mq_r[d].size()), 32'd0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/i2si_fifo_wr_arb.md
Name: i2si_fifo_wr_arb

Overview:
Write-side arbiter that shares the single input port of the i2si byte FIFO between two producers: left-channel and right-channel deserializers. Each producer has a 1-deep holding register. A round-robin or strict L/R alternating grant feeds a registered output stage that drives the FIFO rts/rtr handshake. The block also reports a registered almost-full flag derived from the FIFO occupancy count.

Parameters:
DATA_W, 8, byte width of producer and FIFO data
CNT_W, 4, width of the FIFO occupancy input (FIFO pointer width + 1)
HI_WM, 6, occupancy at or above which almost_full is asserted
STEREO_LOCK, 1, 1 = strict L,R,L,R grant order; 0 = plain round-robin

Ports:
clk  in  1  system clock; all state on its rising edge
rst_n  in  1  reset, asynchronous assert, active-low
req0_rts  in  1  left producer has a byte
req0_data  in  DATA_W  left producer byte
req0_rtr  out  1  arbiter can accept a left byte
req1_rts  in  1  right producer has a byte
req1_data  in  DATA_W  right producer byte
req1_rtr  out  1  arbiter can accept a right byte
fifo_inp_rts  out  1  byte valid toward FIFO
fifo_inp_data  out  DATA_W  byte toward FIFO
fifo_inp_rtr  in  1  FIFO not full
fifo_counter  in  CNT_W  FIFO occupancy
grant_id  out  1  source of the byte in the output stage (0 = left, 1 = right)
almost_full  out  1  registered fifo_counter >= HI_WM

Behaviour:
- Reset (rst_n low, asynchronous):
  - hold_valid[1:0] = 0, out_valid = 0, fifo_inp_data = 0, grant_id = 0, almost_full = 0.
  - last_grant = 1, so the left producer wins first.
  - Bytes in flight are discarded. This applies mid-transfer as well.
- Producer accept:
  - reqN_rtr = !hold_valid[N], taken directly from the register with no combinational path from inputs.
  - When reqN_rts && reqN_rtr at a clk edge, hold_data[N] <= reqN_data and hold_valid[N] <= 1.
- FIFO transfer:
  - Occurs when fifo_inp_rts && fifo_inp_rtr at a clk edge.
  - fifo_inp_rts = out_valid.
  - fifo_inp_data and grant_id are stable while out_valid && !fifo_inp_rtr.
- Output state machine: IDLE (out_valid = 0), PEND (out_valid = 1).
  - A load is allowed in IDLE, or in PEND on a transfer cycle. The latter gives back-to-back throughput of 1 byte/cycle.
  - On a load: out reg <= hold_data[g], grant_id <= g, last_grant <= g, hold_valid[g] <= 0, next state PEND.
  - With no load possible: IDLE stays IDLE; PEND goes to IDLE on transfer, otherwise stays PEND.
  - A hold being cleared this cycle cannot also accept a new byte this cycle, because reqN_rtr was 0.
- Grant selection, STEREO_LOCK = 0:
  - Only one hold valid: grant it.
  - Both valid: grant !last_grant.
  - None valid: no load.
- Grant selection, STEREO_LOCK = 1:
  - Only hold[!last_grant] is eligible.
  - A valid hold[last_grant] waits, and its producer is back-pressured.
- Latency: producer accept edge -> fifo_inp_rts high at the next edge, at minimum 2 edges from reqN_rts sampled.
- FIFO full: fifo_inp_rtr = 0 holds PEND indefinitely. The holds fill and both reqN_rtr drop. No byte is lost or duplicated.
- Simultaneous events:
  - A producer accept and a grant of the other hold in the same cycle are independent.
  - An accept and a transfer in the same cycle are legal.
- almost_full <= (fifo_counter >= HI_WM), one cycle late. Comparison is unsigned CNT_W.
- last_grant is 1 bit and toggles with no wrap concerns.

Decomposition:
- Shared package i2si_pkg holds:
  - constants: I2SI_DATA_W = 8, I2SI_CNT_W = 4, I2SI_CH_L = 0, I2SI_CH_R = 1;
  - the output-state enum (ST_IDLE, ST_PEND).
- One natural sub-module, i2si_hold_reg: a 1-deep rts/rtr holding register, instantiated twice.
- The grant logic and output stage stay in the top module.

Test Plan:
- Reset then idle, fifo_inp_rtr = 1 -> fifo_inp_rts = 0, req0_rtr = req1_rtr = 1, almost_full = 0, grant_id = 0.
- STEREO_LOCK = 0, both producers present bytes every cycle, L = 0x11, 0x12, … and R = 0xA1, 0xA2, …, FIFO always ready -> FIFO receives 0x11, 0xA1, 0x12, 0xA2 with grant_id 0, 1, 0, 1.
- STEREO_LOCK = 1, left sends 0x21 and 0x22 with no right traffic, then right sends 0xB1 -> FIFO receives 0x21, then 0xB1, then 0x22; req0_rtr stays low while 0x22 is held.
- fifo_inp_rtr held 0 for 10 cycles with both producers active -> fifo_inp_data frozen; both reqN_rtr = 0 within 3 cycles; on release all 3 buffered bytes delivered in order with no duplicates.
- fifo_counter driven 5 then 6 then 7 then 5 -> almost_full = 0, 1, 1, 0, each one cycle after the input.
- rst_n pulsed low mid-PEND with byte 0x5A pending -> fifo_inp_rts drops immediately (asynchronously), 0x5A is never delivered, and after release left wins the first grant.
